// File: rtl/ibuff_pkg.sv
// Shared sizing, entry/pointer/count types and helpers for the instruction buffer.
package ibuff_pkg;

   localparam int unsigned DEPTH   = 32;
   localparam int unsigned INDEX   = 5;
   localparam int unsigned WIDTH   = 64;
   localparam int unsigned NUM_WR  = 8;
   localparam int unsigned NUM_RD  = 4;
   localparam int unsigned RDCNT_W = $clog2(NUM_RD) + 1;
   localparam int unsigned WRCNT_W = $clog2(NUM_WR) + 1;

   typedef logic [WIDTH-1:0]   ibuff_entry_t;
   typedef logic [INDEX-1:0]   ibuff_ptr_t;
   typedef logic [INDEX:0]     ibuff_cnt_t;
   typedef logic [WRCNT_W-1:0] ibuff_wrcnt_t;

   function automatic ibuff_wrcnt_t popcount(input logic [NUM_WR-1:0] v);
      ibuff_wrcnt_t c;
      c = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         c = c + ibuff_wrcnt_t'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/ibuff_wr_compact.sv
// Maps sparse write lanes to dense slot offsets from tail, plus the total push count.
module ibuff_wr_compact
   import ibuff_pkg::*;
(
   input  logic [NUM_WR-1:0]              wrValid_i,
   output logic [NUM_WR-1:0][WRCNT_W-1:0] offset_o,
   output logic [WRCNT_W-1:0]             push_cnt_o
);

   // Exclusive prefix sum: lane i lands after all lower set lanes.
   always_comb begin
      for (int i = 0; i < NUM_WR; i++) begin
         offset_o[i] = popcount(wrValid_i & ((NUM_WR'(1) << i) - NUM_WR'(1)));
      end
      push_cnt_o = popcount(wrValid_i);
   end

endmodule

// File: rtl/ibuff_queue.sv
// Multi-port circular instruction buffer between fetch-2 and dispatch.
module ibuff_queue
   import ibuff_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush_i,
   input  logic [NUM_WR-1:0]         wrValid_i,
   input  logic [NUM_WR*WIDTH-1:0]   wrData_i,
   input  logic [RDCNT_W-1:0]        rdCnt_i,
   output logic [NUM_RD*WIDTH-1:0]   rdData_o,
   output logic [NUM_RD-1:0]         rdValid_o,
   output logic [INDEX:0]            count_o,
   output logic                      stall_o
);

   ibuff_entry_t ram_q [DEPTH];
   ibuff_ptr_t   head_q, head_d;
   ibuff_ptr_t   tail_q, tail_d;
   ibuff_cnt_t   count_q, count_d;
   logic         stall_q, stall_d;

   logic [NUM_WR-1:0][WRCNT_W-1:0] offset;
   ibuff_wrcnt_t                   push_cnt;
   ibuff_wrcnt_t                   push_eff;
   ibuff_cnt_t                     rd_req;
   ibuff_cnt_t                     pop_eff;
   logic                           wr_en;

   ibuff_wr_compact u_wr_compact (
      .wrValid_i  (wrValid_i),
      .offset_o   (offset),
      .push_cnt_o (push_cnt)
   );

   // Pop sees pre-push occupancy; dispatch over-ask is clamped to what is held.
   always_comb begin
      wr_en    = !stall_q && !flush_i;
      push_eff = wr_en ? push_cnt : '0;
      rd_req   = ibuff_cnt_t'(rdCnt_i);
      pop_eff  = (rd_req > count_q) ? count_q : rd_req;
   end

   always_comb begin
      head_d  = head_q + ibuff_ptr_t'(pop_eff);
      tail_d  = tail_q + ibuff_ptr_t'(push_eff);
      count_d = count_q + ibuff_cnt_t'(push_eff) - pop_eff;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
      stall_d = (ibuff_cnt_t'(DEPTH) - count_d) < ibuff_cnt_t'(NUM_WR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         stall_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         stall_q <= stall_d;
      end
   end

   // Entry storage is deliberately not reset; validity comes from count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NUM_WR; i++) begin
            if (wrValid_i[i]) begin
               ram_q[tail_q + ibuff_ptr_t'(offset[i])] <= wrData_i[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rdData_o[i*WIDTH +: WIDTH] = ram_q[head_q + ibuff_ptr_t'(i)];
         rdValid_o[i]               = ibuff_cnt_t'(i) < count_q;
      end
      count_o = count_q;
      stall_o = stall_q;
   end

   // Protocol checks on the fetch and dispatch sides.
   always_ff @(posedge clk) begin
      if (!reset && !flush_i) begin
         assert (!(stall_q && (|wrValid_i)))
            else $warning("ibuff_queue: write dropped while stalled");
         assert (rd_req <= count_q)
            else $warning("ibuff_queue: rdCnt_i exceeds count, clamped");
      end
   end

endmodule

// File: tb/tb_ibuff_queue.sv
// Directed and randomised checks of ibuff_queue against a queue-based reference model.
module tb_ibuff_queue;
   import ibuff_pkg::*;

   logic                    clk;
   logic                    reset;
   logic                    flush_i;
   logic [NUM_WR-1:0]       wrValid_i;
   logic [NUM_WR*WIDTH-1:0] wrData_i;
   logic [RDCNT_W-1:0]      rdCnt_i;
   logic [NUM_RD*WIDTH-1:0] rdData_o;
   logic [NUM_RD-1:0]       rdValid_o;
   logic [INDEX:0]          count_o;
   logic                    stall_o;

   logic [63:0] model [$];
   bit          m_stall;
   int          cyc;
   int          n_tests;
   int          n_fail;
   int          wcyc;

   ibuff_queue dut (
      .clk       (clk),
      .reset     (reset),
      .flush_i   (flush_i),
      .wrValid_i (wrValid_i),
      .wrData_i  (wrData_i),
      .rdCnt_i   (rdCnt_i),
      .rdData_o  (rdData_o),
      .rdValid_o (rdValid_o),
      .count_o   (count_o),
      .stall_o   (stall_o)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] lane_data(input int c, input int l);
      return {32'(c) ^ 32'hA5A5_0000, 32'(l) ^ 32'h0000_5A00};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      chk("count", 64'(count_o), 64'(model.size()));
      chk("stall", 64'(stall_o), 64'(m_stall));
      for (int i = 0; i < NUM_RD; i++) begin
         chk($sformatf("rdValid%0d", i), 64'(rdValid_o[i]), 64'(i < model.size()));
         if (i < model.size())
            chk($sformatf("rdData%0d", i), rdData_o[i*WIDTH +: WIDTH], model[i]);
      end
   endtask

   // One clock: apply inputs, advance model, then check one time unit after the edge.
   task automatic step(input logic [7:0] wv, input logic [2:0] rc, input logic fl, input logic rs);
      int pops;
      cyc++;
      for (int l = 0; l < NUM_WR; l++) wrData_i[l*WIDTH +: WIDTH] = lane_data(cyc, l);
      wrValid_i = wv;
      rdCnt_i   = rc;
      flush_i   = fl;
      reset     = rs;
      @(posedge clk);
      if (rs || fl) begin
         model.delete();
         m_stall = 1'b0;
      end else begin
         pops = (int'(rc) > model.size()) ? model.size() : int'(rc);
         repeat (pops) void'(model.pop_front());
         if (!m_stall)
            for (int l = 0; l < NUM_WR; l++)
               if (wv[l]) model.push_back(lane_data(cyc, l));
         m_stall = (DEPTH - model.size()) < NUM_WR;
      end
      #1;
      wrValid_i = '0;
      rdCnt_i   = '0;
      flush_i   = 1'b0;
      reset     = 1'b0;
      check_state();
   endtask

   initial begin
      int rc_max;
      logic [7:0] wv;
      clk = 1'b0; reset = 1'b1; flush_i = 1'b0;
      wrValid_i = '0; wrData_i = '0; rdCnt_i = '0;
      n_tests = 0; n_fail = 0; cyc = 0; m_stall = 1'b0;

      // Reset state
      step(8'h00, 3'd0, 1'b0, 1'b1);
      step(8'h00, 3'd0, 1'b0, 1'b1);
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_valid", 64'(rdValid_o), 64'd0);
      chk("rst_stall", 64'(stall_o), 64'd0);

      // Fill: 8,16,24 not stalled, 32 stalled
      step(8'hFF, 3'd0, 1'b0, 1'b0); chk("fill1_cnt", 64'(count_o), 64'd8);  chk("fill1_stall", 64'(stall_o), 64'd0);
      step(8'hFF, 3'd0, 1'b0, 1'b0); chk("fill2_cnt", 64'(count_o), 64'd16); chk("fill2_stall", 64'(stall_o), 64'd0);
      step(8'hFF, 3'd0, 1'b0, 1'b0); chk("fill3_cnt", 64'(count_o), 64'd24); chk("fill3_stall", 64'(stall_o), 64'd0);
      step(8'hFF, 3'd0, 1'b0, 1'b0); chk("fill4_cnt", 64'(count_o), 64'd32); chk("fill4_stall", 64'(stall_o), 64'd1);
      chk("fill4_lane0", rdData_o[0 +: 64], lane_data(cyc - 3, 0));

      // Sparse write compaction
      step(8'h00, 3'd0, 1'b1, 1'b0);
      step(8'b1010_0101, 3'd0, 1'b0, 1'b0);
      wcyc = cyc;
      chk("sparse_cnt", 64'(count_o), 64'd4);
      chk("sparse_l0", rdData_o[0*64 +: 64], lane_data(wcyc, 0));
      chk("sparse_l1", rdData_o[1*64 +: 64], lane_data(wcyc, 2));
      chk("sparse_l2", rdData_o[2*64 +: 64], lane_data(wcyc, 5));
      chk("sparse_l3", rdData_o[3*64 +: 64], lane_data(wcyc, 7));

      // Over-read clamp with simultaneous push
      step(8'h00, 3'd0, 1'b1, 1'b0);
      step(8'b0000_0011, 3'd0, 1'b0, 1'b0);
      chk("clamp_pre", 64'(count_o), 64'd2);
      step(8'b0000_0111, 3'd4, 1'b0, 1'b0);
      chk("clamp_cnt", 64'(count_o), 64'd3);
      chk("clamp_l0", rdData_o[0 +: 64], lane_data(cyc, 0));
      chk("clamp_l2", rdData_o[128 +: 64], lane_data(cyc, 2));

      // Drive head to 28 and cross the wrap
      step(8'h00, 3'd0, 1'b1, 1'b0);
      step(8'h0F, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 7; k++) step(8'h0F, 3'd4, 1'b0, 1'b0);
      wcyc = cyc;
      chk("wrap_cnt", 64'(count_o), 64'd4);
      chk("wrap_l0", rdData_o[0 +: 64], lane_data(wcyc, 0));
      chk("wrap_l3", rdData_o[192 +: 64], lane_data(wcyc, 3));
      step(8'hFF, 3'd0, 1'b0, 1'b0);
      chk("wrap_cnt2", 64'(count_o), 64'd12);
      chk("wrap_hold", rdData_o[64 +: 64], lane_data(wcyc, 1));
      step(8'h00, 3'd4, 1'b0, 1'b0);
      chk("wrap_cnt3", 64'(count_o), 64'd8);
      chk("wrap_after_l0", rdData_o[0 +: 64], lane_data(wcyc + 1, 0));
      chk("wrap_after_l3", rdData_o[192 +: 64], lane_data(wcyc + 1, 3));

      // Flush dominates same-cycle write and read
      step(8'hFF, 3'd4, 1'b1, 1'b0);
      chk("flush_cnt", 64'(count_o), 64'd0);
      chk("flush_valid", 64'(rdValid_o), 64'd0);
      chk("flush_stall", 64'(stall_o), 64'd0);

      // Reset mid-operation
      step(8'hFF, 3'd0, 1'b0, 1'b0);
      step(8'hFF, 3'd0, 1'b0, 1'b0);
      step(8'hFF, 3'd2, 1'b0, 1'b1);
      chk("midrst_cnt", 64'(count_o), 64'd0);
      chk("midrst_valid", 64'(rdValid_o), 64'd0);

      // Randomised push/pop against the model
      for (int k = 0; k < 3000; k++) begin
         wv = m_stall ? 8'h00 : 8'($urandom);
         rc_max = (model.size() < NUM_RD) ? model.size() : NUM_RD;
         step(wv, 3'($urandom_range(0, rc_max)), 1'($urandom_range(0, 63) == 0), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
